// File: rtl/operand_fetch.sv
// Operand fetch stage: latches an immediate, the accumulator, zero, or a word from one of
// four handshaked neighbour lanes, saturates it to +/-999 and holds it for the ALU.
module operand_fetch (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [2:0]         src,
    input  logic signed [10:0] imm,
    input  logic signed [10:0] acc,
    input  logic [43:0]        port_data,
    input  logic [3:0]         port_valid,
    output logic [3:0]         port_ready,
    input  logic               abort,
    output logic signed [10:0] arg1,
    output logic               arg1_valid,
    input  logic               arg1_ready,
    output logic [1:0]         last_port,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_IMM   = 3'd0,
        SRC_ACC   = 3'd1,
        SRC_NIL   = 3'd2,
        SRC_UP    = 3'd3,
        SRC_DOWN  = 3'd4,
        SRC_LEFT  = 3'd5,
        SRC_RIGHT = 3'd6,
        SRC_ANY   = 3'd7
    } src_t;

    localparam logic signed [10:0] OP_MAX = 11'sd999;
    localparam logic signed [10:0] OP_MIN = -11'sd999;

    state_t             state_q;
    src_t               src_q;
    logic signed [10:0] arg1_q;
    logic               arg1_valid_q;
    logic [1:0]         last_port_q;

    logic [1:0]         sel_lane;
    logic [2:0]         lane_off;
    logic               take;
    logic signed [10:0] lane_data;

    function automatic logic signed [10:0] sat(input logic signed [10:0] v);
        if (v > OP_MAX) return OP_MAX;
        if (v < OP_MIN) return OP_MIN;
        return v;
    endfunction

    // Lane arbitration: a single named lane, or the lowest-index valid lane for ANY; abort masks all.
    always_comb begin
        sel_lane = '0;
        take     = 1'b0;
        lane_off = src_q - 3'd3;
        if (state_q == S_WAIT && !abort) begin
            if (src_q == SRC_ANY) begin
                take = |port_valid;
                if (port_valid[0])      sel_lane = 2'd0;
                else if (port_valid[1]) sel_lane = 2'd1;
                else if (port_valid[2]) sel_lane = 2'd2;
                else                    sel_lane = 2'd3;
            end else begin
                sel_lane = lane_off[1:0];
                take     = port_valid[lane_off[1:0]];
            end
        end
    end

    always_comb begin
        port_ready = take ? (4'b0001 << sel_lane) : '0;
        case (sel_lane)
            2'd0:    lane_data = port_data[10:0];
            2'd1:    lane_data = port_data[21:11];
            2'd2:    lane_data = port_data[32:22];
            default: lane_data = port_data[43:33];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= SRC_IMM;
            arg1_q       <= '0;
            arg1_valid_q <= 1'b0;
            last_port_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        case (src_t'(src))
                            SRC_IMM: begin
                                arg1_q       <= sat(imm);
                                arg1_valid_q <= 1'b1;
                                state_q      <= S_HOLD;
                            end
                            SRC_ACC: begin
                                arg1_q       <= sat(acc);
                                arg1_valid_q <= 1'b1;
                                state_q      <= S_HOLD;
                            end
                            SRC_NIL: begin
                                arg1_q       <= '0;
                                arg1_valid_q <= 1'b1;
                                state_q      <= S_HOLD;
                            end
                            default: begin
                                src_q   <= src_t'(src);
                                state_q <= S_WAIT;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (take) begin
                        arg1_q       <= sat(lane_data);
                        last_port_q  <= sel_lane;
                        arg1_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (abort || arg1_ready) begin
                        arg1_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    arg1_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign arg1       = arg1_q;
    assign arg1_valid = arg1_valid_q;
    assign last_port  = last_port_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch: the driver predicts each delivered operand,
// a negedge monitor pops and compares whenever arg1_valid rises, and checks it stays stable.
module tb_operand_fetch;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req;
    logic [2:0]         src;
    logic signed [10:0] imm;
    logic signed [10:0] acc;
    logic [43:0]        port_data;
    logic [3:0]         port_valid;
    logic [3:0]         port_ready;
    logic               abort;
    logic signed [10:0] arg1;
    logic               arg1_valid;
    logic               arg1_ready;
    logic [1:0]         last_port;
    logic               busy;

    operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .src        (src),
        .imm        (imm),
        .acc        (acc),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .abort      (abort),
        .arg1       (arg1),
        .arg1_valid (arg1_valid),
        .arg1_ready (arg1_ready),
        .last_port  (last_port),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int lane;
    } exp_t;

    exp_t sbq[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   model_last = 0;
    int   model_arg1 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int clamp(input int v);
        if (v > 999) return 999;
        if (v < -999) return -999;
        return v;
    endfunction

    function automatic int lane_val(input logic [43:0] d, input int i);
        logic signed [10:0] w;
        w = d[i*11 +: 11];
        return int'(w);
    endfunction

    function automatic logic [43:0] mk(input int a, input int b, input int c, input int d);
        logic [10:0] x0, x1, x2, x3;
        x0 = a[10:0];
        x1 = b[10:0];
        x2 = c[10:0];
        x3 = d[10:0];
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [43:0] rand_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[43:0];
    endfunction

    // Monitor: compares on each rising arg1_valid, then checks the value holds while valid stays high.
    logic prev_v = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (arg1_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    cur = sbq.pop_front();
                    check("arg1", int'(arg1), cur.val);
                    check("last_port", int'(last_port), cur.lane);
                end
            end else if (arg1_valid) begin
                check("arg1_stable", int'(arg1), cur.val);
            end
            prev_v = arg1_valid;
        end
    end

    task automatic fetch(input int s, input int immv, input int accv,
                         input int wait_n, input bit ab_w, input int hold_n, input bit ab_h,
                         input bit fixed, input logic [3:0] fpv, input logic [43:0] fpd);
        logic [3:0]  pv;
        logic [43:0] pd;
        int          lane;
        exp_t        e;
        @(posedge clk); #1;
        req        = 1'b1;
        src        = s[2:0];
        imm        = immv[10:0];
        acc        = accv[10:0];
        port_valid = '0;
        if (s < 3) begin
            e.val = (s == 0) ? clamp(immv) : (s == 1) ? clamp(accv) : 0;
            e.lane = model_last;
            sbq.push_back(e);
            model_arg1 = e.val;
        end
        @(posedge clk); #1;
        req = 1'b0;
        src = 3'($urandom);
        imm = 11'($urandom);
        acc = 11'($urandom);
        if (s >= 3) begin
            for (int i = 0; i < wait_n; i++) begin
                pv = (s == 7) ? 4'b0000 : (4'($urandom) & ~(4'b0001 << (s - 3)));
                port_valid = pv;
                port_data  = rand_data();
                req        = 1'($urandom);
                #3;
                check("wait_ready", int'(port_ready), 0);
                check("wait_busy", int'(busy), 1);
                @(posedge clk); #1;
            end
            req = 1'b0;
            pd  = fixed ? fpd : rand_data();
            if (ab_w) begin
                pv = (s == 7) ? 4'($urandom_range(1, 15)) : (4'b0001 << (s - 3));
                if (fixed) pv = fpv;
                abort      = 1'b1;
                port_valid = pv;
                port_data  = pd;
                #3;
                check("abort_ready", int'(port_ready), 0);
                @(posedge clk); #1;
                abort      = 1'b0;
                port_valid = '0;
                check("abort_busy", int'(busy), 0);
                check("abort_valid", int'(arg1_valid), 0);
                check("abort_arg1_kept", int'(arg1), model_arg1);
                check("abort_last_kept", int'(last_port), model_last);
                return;
            end
            if (s == 7) pv = 4'($urandom_range(1, 15));
            else        pv = 4'($urandom) | (4'b0001 << (s - 3));
            if (fixed) pv = fpv;
            lane = s - 3;
            if (s == 7) begin
                for (int i = 3; i >= 0; i--) if (pv[i]) lane = i;
            end
            e.val  = clamp(lane_val(pd, lane));
            e.lane = lane;
            sbq.push_back(e);
            model_last = lane;
            model_arg1 = e.val;
            port_valid = pv;
            port_data  = pd;
            #3;
            check("consume_ready", int'(port_ready), 1 << lane);
            @(posedge clk); #1;
            port_valid = '0;
        end
        for (int i = 0; i < hold_n; i++) begin
            arg1_ready = 1'b0;
            req        = 1'($urandom);
            src        = 3'($urandom);
            #3;
            check("hold_valid", int'(arg1_valid), 1);
            check("hold_busy", int'(busy), 1);
            @(posedge clk); #1;
        end
        req = 1'b0;
        if (ab_h) begin
            abort      = 1'b1;
            arg1_ready = 1'($urandom);
        end else begin
            arg1_ready = 1'b1;
        end
        @(posedge clk); #1;
        abort      = 1'b0;
        arg1_ready = 1'b0;
        check("release_busy", int'(busy), 0);
        check("release_valid", int'(arg1_valid), 0);
        check("arg1_retained", int'(arg1), model_arg1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req        = 1'b0;
        src        = '0;
        imm        = '0;
        acc        = '0;
        port_data  = '0;
        port_valid = '0;
        abort      = 1'b0;
        arg1_ready = 1'b0;
        #2;
        check("rst_arg1", int'(arg1), 0);
        check("rst_valid", int'(arg1_valid), 0);
        check("rst_last", int'(last_port), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(port_ready), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        fetch(0, 1023, 0, 0, 0, 0, 0, 0, '0, '0);
        fetch(5, 0, 0, 5, 0, 1, 0, 1, 4'b0100, mk(17, 300, -1010, 44));
        fetch(7, 0, 0, 2, 0, 0, 0, 1, 4'b1010, mk(5, -300, 7, 1200));
        fetch(3, 0, 0, 1, 1, 0, 0, 1, 4'b0001, mk(123, 0, 0, 0));
        fetch(1, 0, -42, 0, 0, 3, 0, 0, '0, '0);
        fetch(0, -1024, 0, 0, 0, 1, 1, 0, '0, '0);
        fetch(2, 500, 500, 0, 0, 0, 0, 0, '0, '0);
        fetch(6, 0, 0, 0, 0, 0, 0, 1, 4'b1000, mk(0, 0, 0, 999));
        fetch(4, 0, 0, 0, 0, 0, 0, 1, 4'b0010, mk(0, -999, 0, 0));

        @(posedge clk); #1;
        abort = 1'b1;
        #3;
        check("idle_abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy2", int'(busy), 0);

        @(posedge clk); #1;
        req = 1'b1;
        src = 3'd6;
        @(posedge clk); #1;
        req        = 1'b0;
        port_valid = '0;
        #1;
        rst_n      = 1'b0;
        port_valid = 4'b1000;
        port_data  = mk(0, 0, 0, 321);
        #1;
        check("midwait_rst_ready", int'(port_ready), 0);
        check("midwait_rst_busy", int'(busy), 0);
        check("midwait_rst_valid", int'(arg1_valid), 0);
        check("midwait_rst_arg1", int'(arg1), 0);
        check("midwait_rst_last", int'(last_port), 0);
        model_last = 0;
        model_arg1 = 0;
        @(negedge clk);
        port_valid = '0;
        rst_n      = 1'b1;
        fetch(6, 0, 0, 1, 0, 0, 0, 1, 4'b1000, mk(0, 0, 0, -321));

        for (int t = 0; t < 50; t++) begin
            fetch($urandom_range(0, 7),
                  int'($urandom_range(0, 2047)) - 1024,
                  int'($urandom_range(0, 2047)) - 1024,
                  $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0),
                  1'b0, '0, '0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (all state on rising edge) and rst_n (asserting it clears all state at once, without waiting for clk).
REQ-002 SHALL provide ports:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  req  in  1  start one operand fetch; sampled only in IDLE
  src  in  3  source: 0 IMM, 1 ACC, 2 NIL, 3 UP, 4 DOWN, 5 LEFT, 6 RIGHT, 7 ANY
  imm  in  11  signed immediate
  acc  in  11  signed accumulator value
  port_data  in  44  four 11-bit signed lanes; [10:0] UP, [21:11] DOWN, [32:22] LEFT, [43:33] RIGHT
  port_valid  in  4  per-lane data available; bit 0 UP .. bit 3 RIGHT
  port_ready  out  4  per-lane consume strobe
  abort  in  1  cancel the fetch in progress
  arg1  out  11  signed operand to ALU
  arg1_valid  out  1  arg1 holds a valid operand
  arg1_ready  in  1  ALU consumes arg1
  last_port  out  2  lane index consumed by the most recent port or ANY fetch
  busy  out  1  high whenever state is not IDLE

Function
REQ-003 SHALL implement states IDLE, WAIT, HOLD; busy = (state != IDLE).
REQ-004 In IDLE with req=1 and src IMM, ACC or NIL: SHALL latch operand (imm, acc, or 0) at that edge and enter HOLD; arg1_valid high the next cycle (1-cycle latency).
REQ-005 In IDLE with req=1 and src 3..7: SHALL latch src and enter WAIT; no port_ready in that cycle.
REQ-006 In WAIT for a single lane: port_ready[lane] SHALL equal port_valid[lane] combinationally; when both are high, data latched at that edge, last_port updated, state goes to HOLD.
REQ-007 In WAIT for ANY: SHALL select the lowest-index lane with port_valid=1 (UP > DOWN > LEFT > RIGHT); only that lane's port_ready asserted; no lane valid -> stay in WAIT.
REQ-008 port_ready SHALL never have more than one bit set and SHALL be 0 outside WAIT.
REQ-009 Every latched operand SHALL be saturated: >999 -> 999, < -999 -> -999, otherwise unchanged (immediates and port data both clamped).
REQ-010 In HOLD: arg1_valid=1 and arg1 stable until arg1_ready=1; on that edge go to IDLE, arg1_valid falls next cycle.
REQ-011 req SHALL be ignored in WAIT and HOLD; a new fetch can start no earlier than the cycle after HOLD exits.
REQ-012 abort in WAIT SHALL return to IDLE with port_ready all 0 that cycle, even if port_valid is high (abort wins; no port data consumed).
REQ-013 abort in HOLD SHALL return to IDLE and drop arg1_valid, overriding a simultaneous arg1_ready; abort in IDLE SHALL have no effect.
REQ-014 arg1 SHALL retain its last value after leaving HOLD; last_port SHALL change only on a port consume.
REQ-015 src, imm and acc SHALL be sampled only at the req edge in IDLE; later changes SHALL not affect the fetch.

Reset
REQ-016 While rst_n=0: state IDLE, arg1=0, arg1_valid=0, last_port=0, busy=0; port_ready=0 combinationally.
REQ-017 Reset asserted in WAIT or HOLD SHALL abandon the fetch with no port consumed; first req after release is accepted normally.

Verification
REQ-018 IMM: req, src=0, imm=1023 -> next cycle arg1=999, arg1_valid=1; arg1_ready=1 -> IDLE, busy=0.
REQ-019 Port block: req, src=5 (LEFT), port_valid=0 for 5 cycles -> busy=1, port_ready=0; port_valid[2]=1, lane=-1010 -> port_ready=4'b0100 that cycle, then arg1=-999, last_port=2.
REQ-020 ANY: src=7, port_valid=4'b1010 -> port_ready=4'b0010, arg1=DOWN lane, last_port=1.
REQ-021 Abort race: in WAIT on UP, abort=1 with port_valid[0]=1 same cycle -> port_ready=0, next state IDLE, arg1_valid=0.
REQ-022 Backpressure: ACC fetch with acc=-42, arg1_ready low 3 cycles -> arg1=-42 held, arg1_valid=1; req pulses ignored.
REQ-023 Reset mid-WAIT: rst_n low while waiting on RIGHT -> all outputs at reset values immediately, port_ready=0.
